// File: rtl/seg_display_scheduler.sv
// Digit-scan and content scheduler for a 4-digit seven-segment display.
// Selects between a live word and a held REQ/ACK message per scan frame.
module seg_display_scheduler #(
    parameter int PRESCALE    = 50000,
    parameter int HOLD_FRAMES = 500
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] LIVE_VALUE,
    input  logic        BLANK_LZ,
    input  logic        MSG_REQ,
    input  logic [15:0] MSG_DATA,
    output logic        MSG_ACK,
    output logic        MSG_ACTIVE,
    output logic [1:0]  DIGIT_SEL,
    output logic [15:0] DISPLAY,
    output logic        FRAME_TICK
);

    typedef enum logic {LIVE, MSG} state_t;

    localparam logic [15:0] PMAX      = 16'(PRESCALE - 1);
    localparam logic [15:0] HOLD_INIT = 16'(HOLD_FRAMES);

    state_t      state;
    logic [15:0] pcnt;
    logic [15:0] hold;
    logic [15:0] msg_buf;
    logic [15:0] sel_word;
    logic [15:0] shown;
    logic        slot;
    logic        frame;
    logic        accept;
    logic        b3;
    logic        b2;
    logic        b1;

    assign slot   = (pcnt == PMAX);
    assign frame  = slot && (DIGIT_SEL == 2'd3);
    assign accept = MSG_REQ && !MSG_ACK;

    // Leading-zero blanking chains from the leftmost digit; digit 0 always shows.
    always_comb begin
        sel_word = (state == MSG) ? msg_buf : LIVE_VALUE;
        shown    = sel_word;
        b3       = BLANK_LZ && (sel_word[15:12] == 4'h0);
        b2       = b3 && (sel_word[11:8] == 4'h0);
        b1       = b2 && (sel_word[7:4] == 4'h0);
        if (b3) shown[15:12] = 4'hF;
        if (b2) shown[11:8]  = 4'hF;
        if (b1) shown[7:4]   = 4'hF;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= LIVE;
            pcnt       <= 16'd0;
            hold       <= 16'd0;
            msg_buf    <= 16'd0;
            DIGIT_SEL  <= 2'd0;
            DISPLAY    <= 16'hFFFF;
            FRAME_TICK <= 1'b0;
            MSG_ACK    <= 1'b0;
            MSG_ACTIVE <= 1'b0;
        end else begin
            FRAME_TICK <= frame;
            pcnt       <= slot ? 16'd0 : pcnt + 16'd1;
            if (slot) DIGIT_SEL <= DIGIT_SEL + 2'd1;

            if (frame) begin
                DISPLAY <= shown;
                if (state == MSG) begin
                    hold <= hold - 16'd1;
                    if (hold == 16'd1) begin
                        state      <= LIVE;
                        MSG_ACTIVE <= 1'b0;
                    end
                end
            end

            // Placed last so an accept overrides a same-cycle final-frame return.
            if (accept) begin
                msg_buf    <= MSG_DATA;
                hold       <= HOLD_INIT;
                state      <= MSG;
                MSG_ACTIVE <= 1'b1;
                MSG_ACK    <= 1'b1;
            end else if (!MSG_REQ) begin
                MSG_ACK <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with PRESCALE=4, HOLD_FRAMES=3.
// Edge numbers count rising clock edges after reset release.
module tb_seg_display_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] live_value;
    logic        blank_lz;
    logic        msg_req;
    logic [15:0] msg_data;
    logic        msg_ack;
    logic        msg_active;
    logic [1:0]  digit_sel;
    logic [15:0] display;
    logic        frame_tick;

    int cyc = 0;
    int total = 0;
    int passed = 0;

    typedef struct {
        logic        blank;
        logic [15:0] live;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    seg_display_scheduler #(.PRESCALE(4), .HOLD_FRAMES(3)) dut (
        .CLK(clk),
        .RST(rst),
        .LIVE_VALUE(live_value),
        .BLANK_LZ(blank_lz),
        .MSG_REQ(msg_req),
        .MSG_DATA(msg_data),
        .MSG_ACK(msg_ack),
        .MSG_ACTIVE(msg_active),
        .DIGIT_SEL(digit_sel),
        .DISPLAY(display),
        .FRAME_TICK(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
        else
            passed++;
    endtask

    task automatic step_to(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_frame(input string name, input int e, input logic [15:0] exp);
        step_to(e);
        chk({name, "_tick"}, {15'd0, frame_tick}, 16'd1);
        chk({name, "_disp"}, display, exp);
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h0005, 16'hFFF5};
        vecs[1] = '{1'b1, 16'h0000, 16'hFFF0};
        vecs[2] = '{1'b1, 16'h0100, 16'hF100};
        vecs[3] = '{1'b0, 16'h0005, 16'h0005};
        vecs[4] = '{1'b1, 16'h0030, 16'hFF30};
        vecs[5] = '{1'b1, 16'h1000, 16'h1000};

        rst        = 1'b1;
        live_value = 16'h1234;
        blank_lz   = 1'b0;
        msg_req    = 1'b0;
        msg_data   = 16'h0000;

        // Scenario 1: reset values and scan timing
        repeat (2) @(posedge clk);
        #1;
        chk("rst_disp", display, 16'hFFFF);
        chk("rst_sel", {14'd0, digit_sel}, 16'd0);
        chk("rst_tick", {15'd0, frame_tick}, 16'd0);
        chk("rst_ack", {15'd0, msg_ack}, 16'd0);
        chk("rst_active", {15'd0, msg_active}, 16'd0);
        rst = 1'b0;
        cyc = 0;
        step_to(3);
        chk("sel_e3", {14'd0, digit_sel}, 16'd0);
        step_to(4);
        chk("sel_e4", {14'd0, digit_sel}, 16'd1);
        step_to(8);
        chk("sel_e8", {14'd0, digit_sel}, 16'd2);
        step_to(15);
        chk("sel_e15", {14'd0, digit_sel}, 16'd3);
        chk("disp_e15", display, 16'hFFFF);
        chk("tick_e15", {15'd0, frame_tick}, 16'd0);
        chk_frame("f16", 16, 16'h1234);
        chk("sel_e16", {14'd0, digit_sel}, 16'd0);
        step_to(17);
        chk("tick_e17", {15'd0, frame_tick}, 16'd0);

        // Scenario 2: single message held for three frames
        step_to(20);
        msg_req  = 1'b1;
        msg_data = 16'hABCD;
        step_to(21);
        chk("s2_ack_up", {15'd0, msg_ack}, 16'd1);
        chk("s2_active", {15'd0, msg_active}, 16'd1);
        msg_req = 1'b0;
        step_to(22);
        chk("s2_ack_down", {15'd0, msg_ack}, 16'd0);
        chk("s2_disp_hold", display, 16'h1234);
        chk_frame("s2_f32", 32, 16'hABCD);
        chk_frame("s2_f48", 48, 16'hABCD);
        step_to(63);
        chk("s2_active63", {15'd0, msg_active}, 16'd1);
        chk_frame("s2_f64", 64, 16'hABCD);
        chk("s2_active64", {15'd0, msg_active}, 16'd0);
        chk_frame("s2_f80", 80, 16'h1234);

        // Scenario 3: newer message reloads hold mid-display
        do_reset();
        step_to(20);
        msg_req  = 1'b1;
        msg_data = 16'hABCD;
        step_to(22);
        msg_req = 1'b0;
        chk_frame("s3_f32", 32, 16'hABCD);
        chk_frame("s3_f48", 48, 16'hABCD);
        step_to(49);
        msg_req  = 1'b1;
        msg_data = 16'h0E0E;
        step_to(50);
        chk("s3_ack", {15'd0, msg_ack}, 16'd1);
        msg_req = 1'b0;
        chk_frame("s3_f64", 64, 16'h0E0E);
        chk_frame("s3_f80", 80, 16'h0E0E);
        chk_frame("s3_f96", 96, 16'h0E0E);
        chk("s3_active96", {15'd0, msg_active}, 16'd0);
        chk_frame("s3_f112", 112, 16'h1234);

        // Scenario 4: accept on the final frame event of a hold
        do_reset();
        step_to(20);
        msg_req  = 1'b1;
        msg_data = 16'hABCD;
        step_to(22);
        msg_req = 1'b0;
        step_to(63);
        msg_req  = 1'b1;
        msg_data = 16'h5A5A;
        chk_frame("s4_f64", 64, 16'hABCD);
        chk("s4_active64", {15'd0, msg_active}, 16'd1);
        msg_req = 1'b0;
        chk_frame("s4_f80", 80, 16'h5A5A);
        chk_frame("s4_f96", 96, 16'h5A5A);
        chk_frame("s4_f112", 112, 16'h5A5A);
        chk("s4_active112", {15'd0, msg_active}, 16'd0);
        chk_frame("s4_f128", 128, 16'h1234);

        // Scenario 5: leading-zero blanking table
        for (int i = 0; i < 6; i++) begin
            blank_lz   = vecs[i].blank;
            live_value = vecs[i].live;
            chk_frame($sformatf("blank%0d", i), 144 + 16 * i, vecs[i].exp);
        end
        blank_lz   = 1'b0;
        live_value = 16'h1234;

        // Scenario 6: reset during message with ACK high
        do_reset();
        step_to(20);
        msg_req  = 1'b1;
        msg_data = 16'hABCD;
        chk_frame("s6_f32", 32, 16'hABCD);
        step_to(39);
        chk("s6_ack_pre", {15'd0, msg_ack}, 16'd1);
        rst = 1'b1;
        #1;
        chk("s6_rst_disp", display, 16'hFFFF);
        chk("s6_rst_ack", {15'd0, msg_ack}, 16'd0);
        chk("s6_rst_active", {15'd0, msg_active}, 16'd0);
        chk("s6_rst_sel", {14'd0, digit_sel}, 16'd0);
        msg_req = 1'b0;
        do_reset();
        chk_frame("s6_f16", 16, 16'h1234);
        chk("s6_active16", {15'd0, msg_active}, 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
